adapt_thresh_stream: RTL

ADAPT_THRESH_STREAM -- requirements
Module: adapt_thresh_stream

---
 rtl/thresh_pkg.sv | 27 ++
 rtl/line_buffer.sv | 25 ++
 rtl/adapt_thresh_stream.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/thresh_pkg.sv
// Shared types and width helpers for the adaptive-threshold streaming block.
package thresh_pkg;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_RUN,
    ST_FLUSH
  } state_t;

  function automatic int calc_s(input int kernel);
    return (kernel - 1) / 2;
  endfunction

  function automatic int calc_n(input int kernel);
    return kernel * kernel;
  endfunction

  function automatic int sum_width(input int pix_w, input int kernel);
    return pix_w + $clog2(kernel * kernel);
  endfunction

  // Wide enough for both sum*100 and pix*N*255 (the ratio term is at most 8 bits).
  function automatic int prod_width(input int pix_w, input int kernel);
    return sum_width(pix_w, kernel) + 8;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage; read and write share the address, so the
// returned word is the pixel from the previous line at the same column.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage gets no reset; stale words are masked by the position counters.
  // NOTE: sequential state is always written with <= so all flops update together.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_din;
  end

  assign o_dout = r_mem[i_addr];

endmodule

// File: rtl/adapt_thresh_stream.sv
// Streaming KxK local-mean binariser: a pixel is dark when the window sum
// exceeds pixel*N*PERCENT/100, with zero padding outside the image.
module adapt_thresh_stream
  import thresh_pkg::*;
#(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int KERNEL  = 3,
  parameter int PERCENT = 110,
  parameter int PIX_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_sof,
  output logic             out_eof
);

  localparam int S     = calc_s(KERNEL);
  localparam int N     = calc_n(KERNEL);
  localparam int SUM_W = sum_width(PIX_W, KERNEL);
  localparam int CMP_W = prod_width(PIX_W, KERNEL);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);

  localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0]    FILL_COL = CW'(S - 1);
  localparam logic [RW-1:0]    FILL_ROW = RW'(S);
  localparam logic [CMP_W-1:0] RATIO    = CMP_W'(N * PERCENT);
  localparam logic [CMP_W-1:0] HUNDRED  = CMP_W'(100);

  state_t r_state, w_state_nx;

  logic [CW-1:0] r_in_col, r_c_col;
  logic [RW-1:0] r_in_row, r_c_row;
  logic          r_out_valid, r_out_bit, r_out_sof, r_out_eof;

  logic [KERNEL-1:0][KERNEL-1:0][PIX_W-1:0] r_win, w_win_nx;
  logic [KERNEL-1:0][PIX_W-1:0]             w_col;
  logic [KERNEL-2:0][PIX_W-1:0]             w_lb_dout;
  logic [KERNEL-1:0]                        w_row_ok, w_col_ok;

  logic             w_out_free, w_adv, w_emit, w_in_last, w_bit;
  logic [PIX_W-1:0] w_new_pix;
  logic [SUM_W-1:0] w_sum;
  logic [CMP_W-1:0] w_lhs, w_rhs;

  assign w_out_free = out_ready || !r_out_valid;
  assign w_in_last  = (r_in_row == ROW_LAST) && (r_in_col == COL_LAST);
  assign w_new_pix  = (r_state == ST_FLUSH) ? '0 : in_pix;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    w_adv      = 1'b0;
    w_emit     = 1'b0;
    case (r_state)
      ST_FILL: begin
        in_ready = w_out_free;
        w_adv    = in_valid && w_out_free;
        if (w_adv && r_in_row == FILL_ROW && r_in_col == FILL_COL) w_state_nx = ST_RUN;
      end
      ST_RUN: begin
        in_ready = w_out_free;
        w_adv    = in_valid && w_out_free;
        w_emit   = w_adv;
        if (w_adv && w_in_last) w_state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_adv  = w_out_free && !(r_out_valid && r_out_eof);
        w_emit = w_adv;
        if (r_out_valid && r_out_eof && out_ready) w_state_nx = ST_FILL;
      end
      default: w_state_nx = ST_FILL;
    endcase
    if (rst) begin
      in_ready = 1'b0;
      w_adv    = 1'b0;
      w_emit   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_state_nx;
  end

  // Line buffer k delivers row (input_row - 1 - k) at the current input column.
  for (genvar g = 0; g < KERNEL - 1; g++) begin : g_lb
    logic [PIX_W-1:0] w_din;
    if (g == 0) begin : g_head
      assign w_din = w_new_pix;
    end else begin : g_chain
      assign w_din = w_lb_dout[g-1];
    end
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb (
      .clk   (clk),
      .i_we  (w_adv),
      .i_addr(r_in_col),
      .i_din (w_din),
      .o_dout(w_lb_dout[g])
    );
  end

  for (genvar j = 0; j < KERNEL; j++) begin : g_row
    if (j == KERNEL - 1) begin : g_newest
      assign w_col[j] = w_new_pix;
    end else begin : g_stored
      assign w_col[j] = w_lb_dout[KERNEL-2-j];
    end
    for (genvar i = 0; i < KERNEL; i++) begin : g_col
      if (i == KERNEL - 1) begin : g_in
        assign w_win_nx[j][i] = w_col[j];
      end else begin : g_shift
        assign w_win_nx[j][i] = r_win[j][i+1];
      end
    end
    // Padding comes from the centre position, never from buffer contents.
    assign w_row_ok[j] = (int'(r_c_row) + j >= S) && (int'(r_c_row) + j - S < IMG_H);
    assign w_col_ok[j] = (int'(r_c_col) + j >= S) && (int'(r_c_col) + j - S < IMG_W);
  end

  always_ff @(posedge clk) begin
    if (w_adv) r_win <= w_win_nx;
  end

  always_comb begin
    w_sum = '0;
    for (int j = 0; j < KERNEL; j++) begin
      for (int i = 0; i < KERNEL; i++) begin
        if (w_row_ok[j] && w_col_ok[i]) w_sum = w_sum + SUM_W'(w_win_nx[j][i]);
      end
    end
  end

  assign w_lhs = CMP_W'(w_sum) * HUNDRED;
  assign w_rhs = CMP_W'(w_win_nx[S][S]) * RATIO;
  assign w_bit = !(w_lhs > w_rhs);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_col <= '0;
      r_in_row <= '0;
      r_c_col  <= '0;
      r_c_row  <= '0;
    end else begin
      if (r_state == ST_FLUSH && w_state_nx == ST_FILL) begin
        r_in_col <= '0;
        r_in_row <= '0;
      end else if (w_adv) begin
        if (r_in_col == COL_LAST) begin
          r_in_col <= '0;
          r_in_row <= (r_in_row == ROW_LAST) ? '0 : r_in_row + 1'b1;
        end else begin
          r_in_col <= r_in_col + 1'b1;
        end
      end
      if (w_emit) begin
        if (r_c_col == COL_LAST) begin
          r_c_col <= '0;
          r_c_row <= (r_c_row == ROW_LAST) ? '0 : r_c_row + 1'b1;
        end else begin
          r_c_col <= r_c_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_bit   <= w_bit;
      r_out_sof   <= (r_c_row == '0) && (r_c_col == '0);
      r_out_eof   <= (r_c_row == ROW_LAST) && (r_c_col == COL_LAST);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign out_sof   = r_out_sof;
  assign out_eof   = r_out_eof;

endmodule
